// File: rtl/rv_pkg.sv
// Shared fetch-stage types and constants: XLEN, default BTB geometry, BTB entry layout, PC step.
package rv_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned BTB_ENTRIES_DFLT = 16;
  localparam int unsigned BTB_IDX_W        = $clog2(BTB_ENTRIES_DFLT);
  localparam int unsigned BTB_TAG_W        = XLEN - BTB_IDX_W - 2;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [XLEN-3:0]      target;
  } btb_entry_t;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/rv_btb_array.sv
// Direct-mapped BTB storage: combinational read, write at the clock edge, async clear of valids.
// A same-cycle read of the written index returns the old contents.
module rv_btb_array
  import rv_pkg::*;
#(
  parameter int unsigned ENTRIES = BTB_ENTRIES_DFLT,
  parameter int unsigned IDX_W   = $clog2(ENTRIES),
  parameter int unsigned TAG_W   = XLEN - IDX_W - 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [XLEN-3:0]  rd_target_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [XLEN-3:0]  wr_target_i
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-3:0]    target_q [ENTRIES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/target payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
    end
  end

  assign rd_valid_o  = valid_q[rd_idx_i];
  assign rd_tag_o    = tag_q[rd_idx_i];
  assign rd_target_o = target_q[rd_idx_i];

endmodule

// File: rtl/rv_fetch_pc_gen.sv
// Fetch PC register plus next-PC select: redirect > stall > BTB-predicted taken > PC+4.
// BTB lookup is same-cycle on the current PC; stall holds the PC unless a redirect arrives.
module rv_fetch_pc_gen
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     BTB_ENTRIES = BTB_ENTRIES_DFLT
) (
  input  logic            i_pcg_clk,
  input  logic            i_pcg_rst,
  input  logic            i_pcg_stall,
  input  logic            i_pcg_pred_taken,
  input  logic            i_pcg_redirect,
  input  logic [XLEN-1:0] i_pcg_redirect_pc,
  input  logic            i_pcg_upd_en,
  input  logic [XLEN-1:0] i_pcg_upd_pc,
  input  logic [XLEN-1:0] i_pcg_upd_target,
  output logic [XLEN-1:0] o_pcg_pc,
  output logic            o_pcg_btb_hit,
  output logic            o_pcg_pred_taken,
  output logic [XLEN-1:0] o_pcg_pred_target
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc_plus4;
  logic             lkp_valid;
  logic [TAG_W-1:0] lkp_tag;
  logic [XLEN-3:0]  lkp_target;
  logic             btb_hit;
  logic             unused_lsbs;

  // Instruction-address LSBs of the update port carry no information.
  assign unused_lsbs = ^{i_pcg_upd_pc[1:0], i_pcg_upd_target[1:0]};

  rv_btb_array #(
    .ENTRIES (BTB_ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_btb (
    .clk_i       (i_pcg_clk),
    .rst_i       (i_pcg_rst),
    .rd_idx_i    (pc_q[IDX_W+1:2]),
    .rd_valid_o  (lkp_valid),
    .rd_tag_o    (lkp_tag),
    .rd_target_o (lkp_target),
    .wr_en_i     (i_pcg_upd_en),
    .wr_idx_i    (i_pcg_upd_pc[IDX_W+1:2]),
    .wr_tag_i    (i_pcg_upd_pc[XLEN-1:IDX_W+2]),
    .wr_target_i (i_pcg_upd_target[XLEN-1:2])
  );

  assign btb_hit  = lkp_valid && (lkp_tag == pc_q[XLEN-1:IDX_W+2]);
  assign pc_plus4 = pc_q + PC_INC;

  assign o_pcg_pc          = pc_q;
  assign o_pcg_btb_hit     = btb_hit;
  assign o_pcg_pred_taken  = btb_hit && i_pcg_pred_taken;
  assign o_pcg_pred_target = btb_hit ? {lkp_target, 2'b00} : pc_plus4;

  always_comb begin
    pc_d = pc_plus4;
    if (i_pcg_redirect) begin
      pc_d = pc_align(i_pcg_redirect_pc);
    end else if (i_pcg_stall) begin
      pc_d = pc_q;
    end else if (o_pcg_pred_taken) begin
      pc_d = o_pcg_pred_target;
    end
  end

  always_ff @(posedge i_pcg_clk or posedge i_pcg_rst) begin
    if (i_pcg_rst) begin
      pc_q <= pc_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_rv_fetch_pc_gen.sv
// Bench for rv_fetch_pc_gen: per-cycle vector table through an expected-value queue,
// then an asynchronous mid-cycle reset sequence.
`timescale 1ns/1ps
module tb_rv_fetch_pc_gen;

  typedef struct {
    logic        stall;
    logic        pt;
    logic        redir;
    logic [31:0] rpc;
    logic        upd;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic [31:0] epc;
    logic        ehit;
    logic        ept;
    logic [31:0] etgt;
  } vec_t;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        pred_taken = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic [31:0] pc;
  logic        btb_hit;
  logic        pt_o;
  logic [31:0] pred_target;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  rv_fetch_pc_gen #(
    .RESET_PC    (32'h0000_0000),
    .BTB_ENTRIES (16)
  ) dut (
    .i_pcg_clk         (clk),
    .i_pcg_rst         (rst),
    .i_pcg_stall       (stall),
    .i_pcg_pred_taken  (pred_taken),
    .i_pcg_redirect    (redirect),
    .i_pcg_redirect_pc (redirect_pc),
    .i_pcg_upd_en      (upd_en),
    .i_pcg_upd_pc      (upd_pc),
    .i_pcg_upd_target  (upd_target),
    .o_pcg_pc          (pc),
    .o_pcg_btb_hit     (btb_hit),
    .o_pcg_pred_taken  (pt_o),
    .o_pcg_pred_target (pred_target)
  );

  function automatic vec_t mk(input logic s, input logic p, input logic r, input logic [31:0] rp,
                              input logic u, input logic [31:0] up, input logic [31:0] ut,
                              input logic [31:0] epc, input logic eh, input logic ep,
                              input logic [31:0] et);
    vec_t v;
    v.stall = s; v.pt = p; v.redir = r; v.rpc = rp;
    v.upd = u; v.upc = up; v.utgt = ut;
    v.epc = epc; v.ehit = eh; v.ept = ep; v.etgt = et;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, sample mid-cycle, then step past the next rising edge.
  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    stall = v.stall; pred_taken = v.pt; redirect = v.redir; redirect_pc = v.rpc;
    upd_en = v.upd; upd_pc = v.upc; upd_target = v.utgt;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("r%0d_pc", idx), pc, e.epc);
    check($sformatf("r%0d_hit", idx), {31'd0, btb_hit}, {31'd0, e.ehit});
    check($sformatf("r%0d_pred_taken", idx), {31'd0, pt_o}, {31'd0, e.ept});
    check($sformatf("r%0d_pred_target", idx), pred_target, e.etgt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    //          st pt rd rpc           up upc           utgt          epc           hit pt tgt
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0000, 0, 0, 32'h0000_0004));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0004, 0, 0, 32'h0000_0008));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0008, 0, 0, 32'h0000_000C));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h10, 32'h80,  32'h0000_000C, 0, 0, 32'h0000_0010));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0010, 1, 1, 32'h0000_0080));
    tbl.push_back(mk(0, 0, 1, 32'h10,       0, 32'h0,  32'h0,   32'h0000_0080, 0, 0, 32'h0000_0084));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0010, 1, 0, 32'h0000_0080));
    tbl.push_back(mk(0, 0, 1, 32'h10,       1, 32'h50, 32'hC0,  32'h0000_0014, 0, 0, 32'h0000_0018));
    tbl.push_back(mk(0, 1, 1, 32'h50,       0, 32'h0,  32'h0,   32'h0000_0010, 0, 0, 32'h0000_0014));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0050, 1, 1, 32'h0000_00C0));
    tbl.push_back(mk(1, 0, 1, 32'h200,      0, 32'h0,  32'h0,   32'h0000_00C0, 0, 0, 32'h0000_00C4));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0200, 0, 0, 32'h0000_0204));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0200, 0, 0, 32'h0000_0204));
    tbl.push_back(mk(0, 0, 1, 32'h1C,       0, 32'h0,  32'h0,   32'h0000_0200, 0, 0, 32'h0000_0204));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_001C, 0, 0, 32'h0000_0020));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h20, 32'h300, 32'h0000_0020, 0, 0, 32'h0000_0024));
    tbl.push_back(mk(0, 0, 1, 32'h20,       0, 32'h0,  32'h0,   32'h0000_0024, 0, 0, 32'h0000_0028));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0020, 1, 1, 32'h0000_0300));
    tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0,   32'h0000_0300, 0, 0, 32'h0000_0304));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  32'h0,   32'hFFFF_FFFC, 0, 0, 32'h0000_0000));
    tbl.push_back(mk(0, 0, 1, 32'h60,       1, 32'h60, 32'h400, 32'h0000_0000, 0, 0, 32'h0000_0004));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0060, 1, 1, 32'h0000_0400));
    tbl.push_back(mk(0, 0, 1, 32'h23,       0, 32'h0,  32'h0,   32'h0000_0400, 0, 0, 32'h0000_0404));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0020, 0, 0, 32'h0000_0024));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h27, 32'h503, 32'h0000_0024, 0, 0, 32'h0000_0028));
    tbl.push_back(mk(0, 0, 1, 32'h24,       0, 32'h0,  32'h0,   32'h0000_0028, 0, 0, 32'h0000_002C));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0024, 1, 1, 32'h0000_0500));
    tbl.push_back(mk(0, 0, 1, 32'h0,        1, 32'h0,  32'h700, 32'h0000_0500, 0, 0, 32'h0000_0504));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0000, 1, 1, 32'h0000_0700));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  32'h0,   32'h0000_0700, 0, 0, 32'h0000_0704));

    #1;
    check("rst_pc", pc, 32'h0000_0000);
    check("rst_hit", {31'd0, btb_hit}, 32'd0);
    check("rst_pred_taken", {31'd0, pt_o}, 32'd0);
    check("rst_pred_target", pred_target, 32'h0000_0004);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(i, tbl[i]);
    end

    // Asynchronous reset between edges: PC and valid bits must drop before any clock edge.
    stall = 1'b0; redirect = 1'b0; upd_en = 1'b0; pred_taken = 1'b1;
    #1;
    check("pre_arst_pc", pc, 32'h0000_0704);
    #1;
    rst = 1'b1;
    #1;
    check("arst_pc", pc, 32'h0000_0000);
    check("arst_hit", {31'd0, btb_hit}, 32'd0);
    check("arst_pred_taken", {31'd0, pt_o}, 32'd0);
    check("arst_pred_target", pred_target, 32'h0000_0004);
    @(posedge clk);
    #1;
    check("arst_hold_pc", pc, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_pc", pc, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("first_adv_pc", pc, 32'h0000_0004);
    check("first_adv_hit", {31'd0, btb_hit}, 32'd0);

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv_fetch_pc_gen.md
# rv_fetch_pc_gen

Fetch-stage next-PC generator with a direct-mapped branch target buffer (BTB). Holds the fetch PC and looks up the BTB for it each cycle. Combines a BTB hit with the direction bit from the 2-bit branch predictor to pick the next PC. Accepts redirects and BTB updates from the execute-stage branch resolution logic.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.
- BTB_ENTRIES, 16: number of BTB entries; power of two, ≥2. IDX_W = log2(BTB_ENTRIES).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - i_pcg_clk  in  1  clock
  - i_pcg_rst  in  1  asynchronous active-high reset
- i_pcg_stall  in  1  hold the fetch PC (hazard unit).
- i_pcg_pred_taken  in  1  direction prediction from the branch predictor.
- i_pcg_redirect  in  1  execute-stage redirect (mispredict or unpredicted jump).
- i_pcg_redirect_pc  in  32  redirect target.
- i_pcg_upd_en  in  1  write a BTB entry (resolved taken branch or jump).
- i_pcg_upd_pc  in  32  PC of the resolved instruction.
- i_pcg_upd_target  in  32  its resolved target.
- o_pcg_pc  out  32  current fetch PC.
- o_pcg_btb_hit  out  1  BTB holds a valid entry for o_pcg_pc.
- o_pcg_pred_taken  out  1  o_pcg_btb_hit && i_pcg_pred_taken; carried down the pipe for mispredict checking.
- o_pcg_pred_target  out  32  BTB target on a hit, else o_pcg_pc+4.

## Operation
- PC register: 32 bits; bits [1:0] always 0. Bits [1:0] of the redirect PC and update target are discarded.
- BTB entry: valid bit, tag = pc[31:IDX_W+2], target[31:2].
- BTB index = pc[IDX_W+1:2].
- Lookup: combinational on o_pcg_pc. A hit requires a valid entry and a matching tag.
- Next-PC priority, highest first:
  - i_pcg_redirect → i_pcg_redirect_pc. A redirect overrides stall.
  - i_pcg_stall → hold the PC.
  - o_pcg_pred_taken → BTB target.
  - Otherwise → PC+4.
- PC+4 wraps modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000.
- Update: when i_pcg_upd_en is high, the entry at index(i_pcg_upd_pc) is written with valid=1, the new tag and the new target. This unconditionally overwrites any alias. Updates are accepted during stall and redirect.
- No invalidation port; entries are cleared only by reset.
- Outputs after reset:
  - o_pcg_pc = RESET_PC
  - o_pcg_btb_hit = 0
  - o_pcg_pred_taken = 0
  - o_pcg_pred_target = RESET_PC+4

## Timing
- Lookup latency 0: hit, prediction and target are valid in the same cycle o_pcg_pc is presented.
- The PC changes at the clock edge following the selecting condition.
- BTB write takes effect at the clock edge. A lookup to the same index in the same cycle returns the old contents (no bypass). The new entry is visible from the next cycle.
- Reset assertion, asynchronous: the PC is forced to RESET_PC and all valid bits clear immediately, mid-operation included. Target/tag storage need not be reset.
- First fetch after reset release: PC RESET_PC; the PC advances at the first clock edge with reset low.
- Redirect and update in the same cycle: both take effect. If the redirect PC indexes the updated entry, the next-cycle lookup sees the new entry.

## Structure
- rv_pkg holds:
  - XLEN = 32
  - the btb_entry_t packed struct (valid, tag, target), tag width derived from BTB_ENTRIES
  - the PC increment constant 4
- Sub-module rv_btb_array: valid, tag and target storage with one combinational read port, one synchronous write port, and async clear of the valid bits.
- Next-PC mux and PC register live in rv_fetch_pc_gen.

## Test plan
- Reset, then 4 cycles with no stall, redirect or update → PC 0x0, 0x4, 0x8, 0xC; hit stays 0.
- Update pc=0x10 → target 0x80, then fetch reaches 0x10 with pred_taken=1 → hit=1, pred_target=0x80, next PC 0x80. Same sequence with pred_taken=0 → next PC 0x14, pred_taken output 0.
- Alias (BTB_ENTRIES=16): update 0x10→0x80, then update 0x50→0xC0. Fetch at 0x10 → hit=0. Fetch at 0x50 → hit=1, target 0xC0.
- Stall and redirect both high with redirect_pc=0x200 → next PC 0x200. Stall alone → PC held for all stalled cycles.
- Update and lookup of PC 0x20 in the same cycle → hit=0 that cycle, hit=1 on a later fetch of 0x20.
- PC=0xFFFF_FFFC with no hit → next PC 0x0. Reset asserted mid-run between clock edges → PC=RESET_PC and hit=0 immediately, before the next edge.
